// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one multi-cycle ALU between two requesters (port 0: pipeline
// execute slot, port 1: auxiliary unit). One operation is in flight at a
// time; the ALU drive is held in registers for the whole ALU latency and
// the captured result is returned tagged with the issuing port.
module alu_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [DATA_W-1:0] req0_imm,
    input  logic [5:0]        req0_funct,
    input  logic [2:0]        req0_alu_op,
    input  logic              req0_alu_src,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [DATA_W-1:0] req1_imm,
    input  logic [5:0]        req1_funct,
    input  logic [2:0]        req1_alu_op,
    input  logic              req1_alu_src,

    output logic [DATA_W-1:0] alu_read_data_1,
    output logic [DATA_W-1:0] alu_read_data_2,
    output logic [DATA_W-1:0] immediate,
    output logic [5:0]        funct,
    output logic [2:0]        alu_op,
    output logic              alu_src,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              ZERO,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero
);

    // Latency counter only needs to hold ALU_LAT-1; keep at least one bit.
    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t            state_q;
    logic              last_grant_q;
    logic [CNT_W-1:0]  lat_cnt_q;
    logic              rsp_id_q;
    logic [DATA_W-1:0] rsp_result_q;
    logic              rsp_zero_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] imm_q;
    logic [5:0]        funct_q;
    logic [2:0]        alu_op_q;
    logic              alu_src_q;

    logic              grant;
    logic              accept;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [DATA_W-1:0] sel_imm;
    logic [5:0]        sel_funct;
    logic [2:0]        sel_alu_op;
    logic              sel_alu_src;

    // Round-robin pick: a lone requester wins outright, a tie goes to the
    // port that was not served last time.
    always_comb begin
        grant = ~last_grant_q;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end
    end

    // Operation fields of the granted port, loaded into the ALU drive on accept.
    always_comb begin
        sel_a       = grant ? req1_a       : req0_a;
        sel_b       = grant ? req1_b       : req0_b;
        sel_imm     = grant ? req1_imm     : req0_imm;
        sel_funct   = grant ? req1_funct   : req0_funct;
        sel_alu_op  = grant ? req1_alu_op  : req0_alu_op;
        sel_alu_src = grant ? req1_alu_src : req0_alu_src;
    end

    // Readies are forced low while reset is asserted so no request is taken
    // in the reset cycle.
    assign req0_ready = (state_q == IDLE) && !rst && !grant;
    assign req1_ready = (state_q == IDLE) && !rst &&  grant;
    assign accept     = grant ? (req1_valid && req1_ready) : (req0_valid && req0_ready);

    // Arbiter FSM: issue in IDLE, count out the ALU latency in EXEC, hold
    // the tagged response in RESP until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            lat_cnt_q    <= '0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            imm_q        <= '0;
            funct_q      <= '0;
            alu_op_q     <= '0;
            alu_src_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q          <= sel_a;
                        b_q          <= sel_b;
                        imm_q        <= sel_imm;
                        funct_q      <= sel_funct;
                        alu_op_q     <= sel_alu_op;
                        alu_src_q    <= sel_alu_src;
                        rsp_id_q     <= grant;
                        last_grant_q <= grant;
                        lat_cnt_q    <= LAT_LOAD;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    if (lat_cnt_q == '0) begin
                        rsp_result_q <= alu_result;
                        rsp_zero_q   <= ZERO;
                        state_q      <= RESP;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign alu_read_data_1 = a_q;
    assign alu_read_data_2 = b_q;
    assign immediate       = imm_q;
    assign funct           = funct_q;
    assign alu_op          = alu_op_q;
    assign alu_src         = alu_src_q;

    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Drives two arbiters: one with the default single-cycle ALU and one with a
// three-cycle ALU stub for the reset-during-execute sequence.
module tb_alu_arbiter;

    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-latency arbiter signals
    logic          rst;
    logic          req0_valid, req0_ready, req0_alu_src;
    logic [DW-1:0] req0_a, req0_b, req0_imm;
    logic [5:0]    req0_funct;
    logic [2:0]    req0_alu_op;
    logic          req1_valid, req1_ready, req1_alu_src;
    logic [DW-1:0] req1_a, req1_b, req1_imm;
    logic [5:0]    req1_funct;
    logic [2:0]    req1_alu_op;
    logic [DW-1:0] alu_read_data_1, alu_read_data_2, immediate, alu_result;
    logic [5:0]    funct;
    logic [2:0]    alu_op;
    logic          alu_src, alu_zero;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [DW-1:0] rsp_result;

    // Three-cycle-latency arbiter signals
    logic          b_rst;
    logic          b_req0_valid, b_req0_ready, b_req0_alu_src;
    logic [DW-1:0] b_req0_a, b_req0_b, b_req0_imm;
    logic [5:0]    b_req0_funct;
    logic [2:0]    b_req0_alu_op;
    logic          b_req1_valid, b_req1_ready, b_req1_alu_src;
    logic [DW-1:0] b_req1_a, b_req1_b, b_req1_imm;
    logic [5:0]    b_req1_funct;
    logic [2:0]    b_req1_alu_op;
    logic [DW-1:0] b_alu_read_data_1, b_alu_read_data_2, b_immediate, b_alu_result;
    logic [5:0]    b_funct;
    logic [2:0]    b_alu_op;
    logic          b_alu_src, b_alu_zero;
    logic          b_rsp_valid, b_rsp_ready, b_rsp_id, b_rsp_zero;
    logic [DW-1:0] b_rsp_result;
    logic [DW-1:0] bStage1, bStage2;

    int total;
    int bad;

    typedef struct packed {
        logic          port;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] imm;
        logic [5:0]    funct;
        logic [2:0]    aluOp;
        logic          aluSrc;
        logic [DW-1:0] expResult;
        logic          expZero;
    } vec_t;

    vec_t vecs [7];

    // ALU stub: add/sub/and/or selected by funct, anything else gives 0.
    function automatic logic [DW-1:0] aluFn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [DW-1:0] imm, input logic [5:0] f,
                                             input logic src);
        logic [DW-1:0] op2;
        logic [DW-1:0] res;
        op2 = src ? imm : b;
        case (f)
            6'b000000: res = a + op2;
            6'b000001: res = a - op2;
            6'b000010: res = a & op2;
            6'b000011: res = a | op2;
            default:   res = '0;
        endcase
        return res;
    endfunction

    // Single-cycle ALU for the default arbiter
    assign alu_result = aluFn(alu_read_data_1, alu_read_data_2, immediate, funct, alu_src);
    assign alu_zero   = (alu_result == '0);

    // Three-cycle ALU: result valid two edges after its inputs settle
    always @(posedge clk) begin
        bStage1 <= aluFn(b_alu_read_data_1, b_alu_read_data_2, b_immediate, b_funct, b_alu_src);
        bStage2 <= bStage1;
    end
    assign b_alu_result = bStage2;
    assign b_alu_zero   = (bStage2 == '0);

    alu_arbiter #(.DATA_W(DW), .ALU_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_imm(req0_imm), .req0_funct(req0_funct), .req0_alu_op(req0_alu_op), .req0_alu_src(req0_alu_src),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_imm(req1_imm), .req1_funct(req1_funct), .req1_alu_op(req1_alu_op), .req1_alu_src(req1_alu_src),
        .alu_read_data_1(alu_read_data_1), .alu_read_data_2(alu_read_data_2), .immediate(immediate),
        .funct(funct), .alu_op(alu_op), .alu_src(alu_src), .alu_result(alu_result), .ZERO(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_zero(rsp_zero)
    );

    alu_arbiter #(.DATA_W(DW), .ALU_LAT(3)) dutLat3 (
        .clk(clk), .rst(b_rst),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_a(b_req0_a), .req0_b(b_req0_b),
        .req0_imm(b_req0_imm), .req0_funct(b_req0_funct), .req0_alu_op(b_req0_alu_op), .req0_alu_src(b_req0_alu_src),
        .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_a(b_req1_a), .req1_b(b_req1_b),
        .req1_imm(b_req1_imm), .req1_funct(b_req1_funct), .req1_alu_op(b_req1_alu_op), .req1_alu_src(b_req1_alu_src),
        .alu_read_data_1(b_alu_read_data_1), .alu_read_data_2(b_alu_read_data_2), .immediate(b_immediate),
        .funct(b_funct), .alu_op(b_alu_op), .alu_src(b_alu_src), .alu_result(b_alu_result), .ZERO(b_alu_zero),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id), .rsp_result(b_rsp_result), .rsp_zero(b_rsp_zero)
    );

    // Advance to just after the next rising edge
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic drivePort(input vec_t v);
        if (v.port) begin
            req1_a = v.a; req1_b = v.b; req1_imm = v.imm;
            req1_funct = v.funct; req1_alu_op = v.aluOp; req1_alu_src = v.aluSrc;
        end else begin
            req0_a = v.a; req0_b = v.b; req0_imm = v.imm;
            req0_funct = v.funct; req0_alu_op = v.aluOp; req0_alu_src = v.aluSrc;
        end
    endtask

    // Garbage on both request buses: the issued op must not follow them
    task automatic scrambleBuses();
        req0_a = 32'hDEADBEEF; req0_b = 32'hDEADBEEF; req0_imm = 32'hDEADBEEF;
        req1_a = 32'hDEADBEEF; req1_b = 32'hDEADBEEF; req1_imm = 32'hDEADBEEF;
        req0_funct = 6'b101010; req1_funct = 6'b101010;
        req0_alu_op = 3'b101; req1_alu_op = 3'b101;
        req0_alu_src = 1'b0; req1_alu_src = 1'b0;
    endtask

    // One isolated operation on the default arbiter, starting from IDLE
    task automatic applyStimulus(input vec_t v, input int idx);
        string p;
        p = $sformatf("vec%0d", idx);
        drivePort(v);
        req0_valid = !v.port;
        req1_valid = v.port;
        #1;
        checkOutput({p, " ready"}, v.port ? req1_ready : req0_ready, 1);
        stepCycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        scrambleBuses();
        #1;
        checkOutput({p, " alu_a"}, alu_read_data_1, v.a);
        checkOutput({p, " alu_b"}, alu_read_data_2, v.b);
        checkOutput({p, " imm"}, immediate, v.imm);
        checkOutput({p, " funct"}, funct, v.funct);
        checkOutput({p, " alu_op"}, alu_op, v.aluOp);
        checkOutput({p, " alu_src"}, alu_src, v.aluSrc);
        checkOutput({p, " exec rsp_valid"}, rsp_valid, 0);
        stepCycle();
        checkOutput({p, " rsp_valid"}, rsp_valid, 1);
        checkOutput({p, " rsp_id"}, rsp_id, v.port);
        checkOutput({p, " rsp_result"}, rsp_result, v.expResult);
        checkOutput({p, " rsp_zero"}, rsp_zero, v.expZero);
        stepCycle();
        checkOutput({p, " done rsp_valid"}, rsp_valid, 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic exp;
        total = 0;
        bad   = 0;

        vecs[0] = '{1'b0, 32'd3, 32'd7, 32'd0, 6'b000000, 3'b000, 1'b0, 32'd10, 1'b0};
        vecs[1] = '{1'b1, 32'd3, 32'd0, 32'd5, 6'b000000, 3'b011, 1'b1, 32'd8, 1'b0};
        vecs[2] = '{1'b0, 32'd5, 32'd5, 32'd0, 6'b000001, 3'b010, 1'b0, 32'd0, 1'b1};
        vecs[3] = '{1'b1, 32'h0000F0F0, 32'h00000FF0, 32'd0, 6'b000010, 3'b010, 1'b0, 32'h000000F0, 1'b0};
        vecs[4] = '{1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 6'b000000, 3'b010, 1'b0, 32'd0, 1'b1};
        vecs[5] = '{1'b1, 32'd6, 32'd9, 32'd0, 6'b111111, 3'b111, 1'b0, 32'd0, 1'b1};
        vecs[6] = '{1'b0, 32'd10, 32'd99, 32'hFFFFFFFE, 6'b000000, 3'b000, 1'b1, 32'd8, 1'b0};

        // Reset with both ports already requesting (contention operands)
        rst = 1'b1; b_rst = 1'b1;
        rsp_ready = 1'b1; b_rsp_ready = 1'b1;
        req0_a = 32'd7; req0_b = 32'd3; req0_imm = '0; req0_funct = 6'b000001; req0_alu_op = 3'b010; req0_alu_src = 1'b0;
        req1_a = 32'd8; req1_b = 32'd4; req1_imm = '0; req1_funct = 6'b000011; req1_alu_op = 3'b010; req1_alu_src = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        b_req0_valid = 1'b0; b_req1_valid = 1'b0;
        b_req0_a = '0; b_req0_b = '0; b_req0_imm = '0; b_req0_funct = '0; b_req0_alu_op = '0; b_req0_alu_src = 1'b0;
        b_req1_a = '0; b_req1_b = '0; b_req1_imm = '0; b_req1_funct = '0; b_req1_alu_op = '0; b_req1_alu_src = 1'b0;
        stepCycle();
        stepCycle();
        checkOutput("reset req0_ready", req0_ready, 0);
        checkOutput("reset req1_ready", req1_ready, 0);
        checkOutput("reset rsp_valid", rsp_valid, 0);
        checkOutput("reset rsp_id", rsp_id, 0);
        checkOutput("reset rsp_result", rsp_result, 0);
        checkOutput("reset rsp_zero", rsp_zero, 0);
        checkOutput("reset alu_a", alu_read_data_1, 0);
        checkOutput("reset alu_b", alu_read_data_2, 0);
        checkOutput("reset imm", immediate, 0);
        checkOutput("reset funct", funct, 0);
        checkOutput("reset alu_op", alu_op, 0);
        checkOutput("reset alu_src", alu_src, 0);

        // Contention: both held valid, grants alternate 0,1,0 three cycles apart
        rst = 1'b0; b_rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            exp = (k % 2 == 1);
            checkOutput($sformatf("cont%0d req0_ready", k), req0_ready, !exp);
            checkOutput($sformatf("cont%0d req1_ready", k), req1_ready, exp);
            stepCycle();
            checkOutput($sformatf("cont%0d alu_a", k), alu_read_data_1, exp ? 32'd8 : 32'd7);
            checkOutput($sformatf("cont%0d funct", k), funct, exp ? 32'd3 : 32'd1);
            checkOutput($sformatf("cont%0d exec rsp_valid", k), rsp_valid, 0);
            checkOutput($sformatf("cont%0d exec readies", k), {req0_ready, req1_ready}, 0);
            stepCycle();
            checkOutput($sformatf("cont%0d rsp_valid", k), rsp_valid, 1);
            checkOutput($sformatf("cont%0d rsp_id", k), rsp_id, exp);
            checkOutput($sformatf("cont%0d rsp_result", k), rsp_result, exp ? 32'd12 : 32'd4);
            stepCycle();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Backpressure: response held 5 cycles while port 1 waits
        req0_a = 32'd20; req0_b = 32'd22; req0_funct = 6'b000000; req0_alu_op = 3'b000;
        req0_valid = 1'b1;
        rsp_ready = 1'b0;
        #1;
        checkOutput("bp req0_ready", req0_ready, 1);
        stepCycle();
        req0_valid = 1'b0;
        req1_a = 32'd1; req1_b = 32'd2; req1_funct = 6'b000000; req1_alu_op = 3'b000;
        req1_valid = 1'b1;
        #1;
        checkOutput("bp exec req1_ready", req1_ready, 0);
        stepCycle();
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp%0d rsp_valid", i), rsp_valid, 1);
            checkOutput($sformatf("bp%0d rsp_id", i), rsp_id, 0);
            checkOutput($sformatf("bp%0d rsp_result", i), rsp_result, 32'd42);
            checkOutput($sformatf("bp%0d rsp_zero", i), rsp_zero, 0);
            checkOutput($sformatf("bp%0d readies", i), {req0_ready, req1_ready}, 0);
            stepCycle();
        end
        rsp_ready = 1'b1;
        #1;
        checkOutput("bp release rsp_valid", rsp_valid, 1);
        checkOutput("bp release req1_ready", req1_ready, 0);
        stepCycle();
        checkOutput("bp idle req1_ready", req1_ready, 1);
        stepCycle();
        req1_valid = 1'b0;
        checkOutput("bp p1 alu_a", alu_read_data_1, 32'd1);
        stepCycle();
        checkOutput("bp p1 rsp_valid", rsp_valid, 1);
        checkOutput("bp p1 rsp_id", rsp_id, 1);
        checkOutput("bp p1 rsp_result", rsp_result, 32'd3);
        stepCycle();
        checkOutput("bp p1 done rsp_valid", rsp_valid, 0);

        // Table of isolated single-port operations
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Three-cycle ALU: reset in the second execute cycle drops the op
        b_req0_a = 32'd2; b_req0_b = 32'd3; b_req0_funct = 6'b000000;
        b_req0_valid = 1'b1;
        #1;
        checkOutput("lat3 req0_ready", b_req0_ready, 1);
        stepCycle();
        b_req0_valid = 1'b0;
        checkOutput("lat3 exec1 alu_a", b_alu_read_data_1, 32'd2);
        stepCycle();
        b_rst = 1'b1;
        #1;
        checkOutput("lat3 rst req0_ready", b_req0_ready, 0);
        checkOutput("lat3 rst req1_ready", b_req1_ready, 0);
        stepCycle();
        b_rst = 1'b0;
        #1;
        checkOutput("lat3 post rsp_valid", b_rsp_valid, 0);
        checkOutput("lat3 post rsp_result", b_rsp_result, 0);
        checkOutput("lat3 post rsp_zero", b_rsp_zero, 0);
        checkOutput("lat3 post alu_a", b_alu_read_data_1, 0);
        checkOutput("lat3 post alu_b", b_alu_read_data_2, 0);
        checkOutput("lat3 post funct", b_funct, 0);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("lat3 dropped%0d rsp_valid", i), b_rsp_valid, 0);
            stepCycle();
        end

        // Fresh op after the abandoned one: response in cycle T+4
        b_req0_a = 32'd9; b_req0_b = 32'd1; b_req0_funct = 6'b000000;
        b_req0_valid = 1'b1;
        #1;
        checkOutput("lat3 new req0_ready", b_req0_ready, 1);
        stepCycle();
        b_req0_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            checkOutput($sformatf("lat3 exec%0d rsp_valid", i), b_rsp_valid, 0);
            stepCycle();
        end
        checkOutput("lat3 new rsp_valid", b_rsp_valid, 1);
        checkOutput("lat3 new rsp_id", b_rsp_id, 0);
        checkOutput("lat3 new rsp_result", b_rsp_result, 32'd10);
        checkOutput("lat3 new rsp_zero", b_rsp_zero, 0);
        stepCycle();
        checkOutput("lat3 new done rsp_valid", b_rsp_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single `execute_module` ALU between two requesters, the pipeline execute slot (port 0) and an auxiliary unit such as an address/branch calculator (port 1). It grants one operation at a time round-robin, drives and holds the ALU operand/control inputs from registers, and waits a fixed ALU latency. It then captures `alu_result`/`ZERO` and returns them tagged with the requester id over a valid/ready response channel.

## Interface
- `DATA_W`, 32, operand/result width
- `ALU_LAT`, 1, cycles (≥1) from ALU inputs becoming stable to `alu_result` being valid
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `reqN_valid`  in  1  (N=0,1) requester N presents an operation
- `reqN_ready`  out  1  operation accepted this cycle when `reqN_valid && reqN_ready`
- `reqN_a`, `reqN_b`, `reqN_imm`  in  DATA_W  operand 1, operand 2, sign-extended immediate (shamt in imm[10:6])
- `reqN_funct`  in  6  funct code
- `reqN_alu_op`  in  3  ALU op class
- `reqN_alu_src`  in  1  select immediate as operand 2
- `alu_read_data_1`, `alu_read_data_2`, `immediate`  out  DATA_W  registered drive to ALU
- `funct`  out  6, `alu_op`  out  3, `alu_src`  out  1  registered drive to ALU
- `alu_result`  in  DATA_W, `ZERO`  in  1  from ALU
- `rsp_valid`  out  1  response held until taken
- `rsp_ready`  in  1  consumer takes response
- `rsp_id`  out  1  requester that issued the op
- `rsp_result`  out  DATA_W, `rsp_zero`  out  1  captured ALU outputs

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - `reqN_ready = (state==IDLE) && grant==N`, combinational.
  - grant: the sole valid requester. If both are valid, the requester other than `last_grant` wins.
  - On accept, load all ALU drive registers from the granted port, set `rsp_id`/`last_grant`, load `lat_cnt = ALU_LAT-1`, and go to EXEC.
  - With no valid requests, stay in IDLE. ALU drive registers hold their last values.
- EXEC:
  - ALU inputs are stable. `lat_cnt` decrements each cycle.
  - On the cycle with `lat_cnt==0`, the edge captures `alu_result`→`rsp_result` and `ZERO`→`rsp_zero`, and the FSM goes to RESP.
- RESP:
  - `rsp_valid=1`. `rsp_id`, `rsp_result` and `rsp_zero` are stable until `rsp_ready`.
  - On `rsp_valid && rsp_ready`, go to IDLE.
  - `rsp_ready` has no effect outside RESP.
- Both `reqN_ready` are 0 in EXEC and RESP. Requesters hold `valid` and operands until accepted, and the arbiter never reads the request buses after acceptance.
- The arbiter never inspects `funct`/`alu_op` contents. Operations not defined by the ALU are passed through unchanged.
- Reset values: `rsp_valid=0`, `rsp_id=0`, `rsp_result=0`, `rsp_zero=0`, all ALU drive outputs 0 (funct=000000, alu_op=000, alu_src=0), `last_grant=1` so port 0 wins the first tie, `lat_cnt=0`, and both `reqN_ready=0` during the reset cycle.
- Reset asserted mid-operation (EXEC or RESP) abandons the operation. No response is produced for it, and the requester sees no second ready.

## Timing
- Accept edge at cycle T. ALU inputs are valid in cycle T+1.
- EXEC occupies cycles T+1 … T+ALU_LAT. `rsp_valid` rises in cycle T+ALU_LAT+1.
- With `rsp_ready` held high, the FSM returns to IDLE one cycle after `rsp_valid` rises. The next accept is possible in that cycle.
- Minimum issue interval is ALU_LAT+2 cycles (3 for default).
- Fairness:
  - With both ports continuously valid, grants strictly alternate 0,1,0,1…
  - A requester waits at most one other operation.
- A request arriving while busy sees `ready=0` and waits. It is evaluated against `last_grant` when IDLE is re-entered.

## Test plan
- Single op, port 0: a=3, b=7, funct=000000, alu_op=000, alu_src=0.
  - `req0_ready` is high in the first IDLE cycle.
  - `rsp_valid` rises 2 cycles after accept with `rsp_id=0`, `rsp_result=10`, `rsp_zero=0`.
- Immediate op, port 1 only: a=3, imm=5, alu_op=011, alu_src=1.
  - `alu_src` output is 1 during EXEC.
  - Response has `rsp_id=1`, `rsp_result=8`.
- Contention: both valid from reset, with port 0 doing 7−3 (funct 000001) and port 1 doing 8|4 (funct 000011), both held after completion.
  - Port 0 is served first, giving result 4, then port 1, giving 12, then port 0 again.
  - Grants alternate, and accepts are spaced 3 cycles apart.
- Backpressure: `rsp_ready=0` for 5 cycles after `rsp_valid`.
  - The response stays stable for those cycles.
  - Both `reqN_ready` stay 0, and a pending port-1 request is accepted only after the handshake.
- Zero flag: port 0 does 5−5 (funct 000001).
  - Response gives `rsp_result=0`, `rsp_zero=1`.
- Reset mid-EXEC with ALU_LAT=3: assert `rst` in the second EXEC cycle.
  - Next cycle: all outputs are at reset values and `rsp_valid` never pulses for the dropped op.
  - A new op is accepted normally afterwards.
